// File: rtl/piano_key_encoder_if.sv
// Piano key encoder bus: raw button levels in, registered note code out.
// master = encoder side, slave = stimulus/consumer side.
interface piano_key_encoder_if #(
  parameter int NUM_KEYS = 7
);
  logic [NUM_KEYS-1:0] key_raw;
  logic                oct_up;
  logic                oct_dn;
  logic [3:0]          note;
  logic [2:0]          octave;
  logic [5:0]          fullnote;
  logic                note_valid;
  logic                note_on;

  modport master (
    input  key_raw, oct_up, oct_dn,
    output note, octave, fullnote,
    output note_valid, note_on
  );

  modport slave (
    output key_raw, oct_up, oct_dn,
    input  note, octave, fullnote,
    input  note_valid, note_on
  );
endinterface

// File: rtl/piano_key_encoder.sv
// Piano key encoder: sync + debounce buttons, priority-pick a key,
// track octave, emit registered fullnote = octave*12 + note.
// Ports: clk, rst (sync, active-high), bus (piano_key_encoder_if.master):
//   key_raw/oct_up/oct_dn in; note, octave, fullnote, note_valid, note_on out.
// Optional macro KEY_SUSTAIN_EN: hold the note SUSTAIN_CYCLES after release.
module piano_key_encoder #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OCT_RESET       = 2,
  parameter int SUSTAIN_CYCLES  = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  piano_key_encoder_if.master bus
);
  localparam int NI = NUM_KEYS + 2;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] OCT_R  = 3'(OCT_RESET);
  localparam logic [5:0] FULL_R = 6'(OCT_RESET * 12);

`ifdef KEY_SUSTAIN_EN
  localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(SUSTAIN_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;
  logic [SW-1:0] sus_cnt;
`else
  typedef enum logic [0:0] {IDLE, PLAY} state_t;
`endif

  state_t state;

  logic [NI-1:0] raw;
  logic [NI-1:0] s1;
  logic [NI-1:0] s2;
  logic [NI-1:0] stab;

  assign raw = {bus.oct_dn, bus.oct_up, bus.key_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NI; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          st;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (s2[i] == st) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        st  <= s2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign stab[i] = st;
  end

  logic [NUM_KEYS-1:0] keys;
  logic                any_key;
  logic                up_st;
  logic                dn_st;
  logic                up_q;
  logic                dn_q;
  logic                up_r;
  logic                dn_r;
  logic [3:0]          sel;

  assign keys    = stab[NUM_KEYS-1:0];
  assign up_st   = stab[NUM_KEYS];
  assign dn_st   = stab[NUM_KEYS+1];
  assign any_key = |keys;
  assign up_r    = up_st & ~up_q;
  assign dn_r    = dn_st & ~dn_q;

  // Walk high-to-low so the lowest pressed index wins.
  always_comb begin
    sel = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (keys[i]) sel = 4'(i);
  end

  logic [3:0] note_q;
  logic [2:0] oct_q;
  logic [5:0] full_q;
  logic       valid_q;
  logic       on_q;
  logic [3:0] nxt_note;
  logic [2:0] nxt_oct;
  logic [5:0] nxt_full;

  always_comb begin
    nxt_note = any_key ? sel : note_q;
    nxt_oct  = oct_q;
    unique case (1'b1)
      up_r & ~dn_r & (oct_q != 3'd4): nxt_oct = oct_q + 3'd1;
      dn_r & ~up_r & (oct_q != 3'd0): nxt_oct = oct_q - 3'd1;
      default: ;
    endcase
    // Built from next-state values so it lines up with note/octave.
    nxt_full = 6'(nxt_oct) * 6'd12 + 6'(nxt_note);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      note_q  <= '0;
      oct_q   <= OCT_R;
      full_q  <= FULL_R;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
`ifdef KEY_SUSTAIN_EN
      sus_cnt <= '0;
`endif
    end else begin
      note_q <= nxt_note;
      oct_q  <= nxt_oct;
      full_q <= nxt_full;
      up_q   <= up_st;
      dn_q   <= dn_st;
      on_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_key) begin
            state   <= PLAY;
            valid_q <= 1'b1;
            on_q    <= 1'b1;
          end
        end
        PLAY: begin
          if (!any_key) begin
`ifdef KEY_SUSTAIN_EN
            state   <= SUSTAIN;
            sus_cnt <= SMAX;
`else
            state   <= IDLE;
            valid_q <= 1'b0;
`endif
          end else begin
            on_q <= (nxt_note != note_q);
          end
        end
`ifdef KEY_SUSTAIN_EN
        SUSTAIN: begin
          if (any_key) begin
            state <= PLAY;
            on_q  <= (nxt_note != note_q);
          end else if (sus_cnt == '0) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end else begin
            sus_cnt <= sus_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
`endif
      endcase
    end
  end

  assign bus.note       = note_q;
  assign bus.octave     = oct_q;
  assign bus.fullnote   = full_q;
  assign bus.note_valid = valid_q;
  assign bus.note_on    = on_q;
endmodule

// File: tb/tb_piano_key_encoder.sv
// Bench for piano_key_encoder: directed stimulus, expected output
// changes queued with their cycle, checked by a negedge monitor.
module tb_piano_key_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piano_key_encoder_if #(.NUM_KEYS(7)) bus ();

  piano_key_encoder #(
    .NUM_KEYS(7),
    .DEBOUNCE_CYCLES(4),
    .OCT_RESET(2),
    .SUSTAIN_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] oct;
    logic [5:0] full;
    logic       valid;
    logic       on;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  exp_t q[$];
  exp_t e;
  out_t prev;
  out_t cur;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input logic [3:0] n,
                      input logic [2:0] o, input logic [5:0] f,
                      input logic v, input logic p);
    exp_t x;
    x.cyc = at;
    x.o   = '{n, o, f, v, p};
    q.push_back(x);
  endtask

  // New-note event: pulse cycle, then pulse falls next cycle.
  task automatic pulse(input int at, input logic [3:0] n,
                       input logic [2:0] o, input logic [5:0] f);
    push(at, n, o, f, 1'b1, 1'b1);
    push(at + 1, n, o, f, 1'b1, 1'b0);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Octave buttons: press, hold, release; note held at 1 throughout.
  task automatic oct_btn(input logic u, input logic d, input logic chg,
                         input logic [2:0] o, input logic [5:0] f);
    bus.oct_up = u;
    bus.oct_dn = d;
    if (chg) push(cyc + 7, 4'd1, o, f, 1'b1, 1'b0);
    step(10);
    bus.oct_up = 1'b0;
    bus.oct_dn = 1'b0;
    step(10);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur = '{bus.note, bus.octave, bus.fullnote,
              bus.note_valid, bus.note_on};
      if (cur != prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.o !== cur || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got %h @%0d want %h @%0d",
                     cur, cyc, e.o, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  int r;

  initial begin
    rst = 1'b1;
    bus.key_raw = 7'h7F;
    bus.oct_up = 1'b0;
    bus.oct_dn = 1'b0;
    step(3);
    bus.key_raw = 7'h00;
    step(3);
    chk("rst note", int'(bus.note), 0);
    chk("rst octave", int'(bus.octave), 2);
    chk("rst fullnote", int'(bus.fullnote), 24);
    chk("rst note_valid", int'(bus.note_valid), 0);
    chk("rst note_on", int'(bus.note_on), 0);
    rst = 1'b0;
    prev = '{4'd0, 3'd2, 6'd24, 1'b0, 1'b0};
    mon_en = 1'b1;
    step(10);

    // 2-cycle bounce on key 3 must not register
    bus.key_raw = 7'h08;
    step(2);
    bus.key_raw = 7'h00;
    step(2);
    bus.key_raw = 7'h08;
    pulse(cyc + 7, 4'd3, 3'd2, 6'd27);
    step(12);

    // key 1 added: lower index wins
    bus.key_raw = 7'h0A;
    pulse(cyc + 7, 4'd1, 3'd2, 6'd25);
    step(12);

    // octave up to saturation, both together, then down
    oct_btn(1'b1, 1'b0, 1'b1, 3'd3, 6'd37);
    oct_btn(1'b1, 1'b0, 1'b1, 3'd4, 6'd49);
    oct_btn(1'b1, 1'b0, 1'b0, 3'd4, 6'd49);
    oct_btn(1'b1, 1'b1, 1'b0, 3'd4, 6'd49);
    oct_btn(1'b0, 1'b1, 1'b1, 3'd3, 6'd37);

    // release lowest key while key 3 held
    bus.key_raw = 7'h08;
    pulse(cyc + 7, 4'd3, 3'd3, 6'd39);
    step(12);

    // release all, re-press same key 6 cycles later
    bus.key_raw = 7'h00;
    r = cyc;
`ifndef KEY_SUSTAIN_EN
    push(r + 7, 4'd3, 3'd3, 6'd39, 1'b0, 1'b0);
    pulse(r + 13, 4'd3, 3'd3, 6'd39);
`endif
    step(6);
    bus.key_raw = 7'h08;
    step(14);

    // one-cycle reset during PLAY, key still held
    rst = 1'b1;
    r = cyc;
    push(r + 1, 4'd0, 3'd2, 6'd24, 1'b0, 1'b0);
    pulse(r + 8, 4'd3, 3'd2, 6'd27);
    step(1);
    rst = 1'b0;
    step(14);

    // final release: note holds, valid drops
    bus.key_raw = 7'h00;
`ifdef KEY_SUSTAIN_EN
    push(cyc + 15, 4'd3, 3'd2, 6'd27, 1'b0, 1'b0);
`else
    push(cyc + 7, 4'd3, 3'd2, 6'd27, 1'b0, 1'b0);
`endif
    step(25);

    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing event: want %h @%0d", e.o, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
